// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak permutation core and its arbiter.
package keccak_pkg;

  localparam int unsigned KECCAK_ROUNDS      = 24;
  localparam int unsigned KECCAK_ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT,
    ARB_RELEASE
  } arb_state_e;

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr_i, with
// wrap-around at N.
module keccak_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
    off = '0;
    // Scan downwards so the lowest set bit of the rotated vector wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o   = sum[IW-1:0];
    valid_o = |req_i;
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter that shares one Keccak permutation core among NUM_REQ
// requesters. Each grant covers one permutation, and a watchdog covers a core that hangs.
//   state       | meaning
//   ARB_IDLE    | no owner; arbitrate when a request is present and the core is ready
//   ARB_START   | one-cycle core start pulse; clear the watchdog
//   ARB_WAIT    | permutation running; wait for core done or the watchdog
//   ARB_RELEASE | completion pulse to the owner; advance the round-robin pointer
module keccak_arbiter import keccak_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = KECCAK_ARB_TIMEOUT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       core_start_o,
  input  logic                       core_ready_i,
  input  logic                       core_done_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  keccak_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid && core_ready_i) begin
          idx_d   = pick_idx;
          state_d = ARB_START;
        end
      end
      ARB_START: begin
        timer_d = '0;
        err_d   = 1'b0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (timer_q != T_LAST) timer_d = timer_q + TW'(1);
        // A done arriving on the same cycle as the timeout is treated as success.
        if (core_done_i) begin
          err_d   = 1'b0;
          state_d = ARB_RELEASE;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        ptr_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  logic [NUM_REQ-1:0] owner_oh;
  assign owner_oh = NUM_REQ'(1) << idx_q;

  assign gnt_o        = (state_q != ARB_IDLE) ? owner_oh : '0;
  assign done_o       = (state_q == ARB_RELEASE) ? owner_oh : '0;
  assign err_o        = (state_q == ARB_RELEASE) && err_q;
  assign busy_o       = (state_q != ARB_IDLE);
  assign core_start_o = (state_q == ARB_START);
  assign gnt_idx_o    = idx_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter with NUM_REQ=4, TIMEOUT=64; the bench plays the core.
module tb_keccak_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic [3:0] done;
  logic       err, busy, start;
  logic       core_ready, core_done;

  int checks = 0;
  int failures = 0;
  int cyc, done_seen, start_seen;

  always #5 clk = ~clk;

  keccak_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .core_start_o (start),
    .core_ready_i (core_ready),
    .core_done_i  (core_done)
  );

  // Advance one cycle; cyc=1 is the START cycle of the current grant.
  task automatic adv();
    @(negedge clk);
    cyc++;
    if (done !== 4'b0000) done_seen++;
    if (start) start_seen++;
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) adv();
  endtask

  task automatic wait_grant(output int idle, output bit ok);
    idle = 0;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
      idle++;
    end
    cyc = 1;
    done_seen = 0;
    start_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; core_done = 1'b0; core_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; core_done = 1'b1; core_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (done !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err: got %b/%b expected 0000/0", done, err); end
    checks++; if (busy !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL reset_busy_start: got %b/%b expected 0/0", busy, start); end
    checks++; if (gnt_idx !== 2'd0) begin failures++; $display("FAIL reset_gnt_idx: got %0d expected 0", gnt_idx); end
    rst = 1'b0; req = '0; core_done = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_after: busy got %b expected 0", busy); end
  endtask

  task automatic test_single();
    req = 4'b0100;
    @(negedge clk);
    cyc = 1; done_seen = 0; start_seen = 0;
    checks++; if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin failures++; $display("FAIL single_gnt: got %b idx %0d expected 0100 idx 2", gnt, gnt_idx); end
    checks++; if (start !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_start: start/busy got %b/%b expected 1/1", start, busy); end
    adv_to(27);
    core_done = 1'b1;
    adv();
    checks++; if (done !== 4'b0100 || err !== 1'b0) begin failures++; $display("FAIL single_done: got %b err %b expected 0100 err 0", done, err); end
    checks++; if (done_seen !== 1 || start_seen !== 0) begin failures++; $display("FAIL single_pulses: done %0d start %0d expected 1 and 0", done_seen, start_seen); end
    core_done = 1'b0; req = '0;
    adv();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL single_release: gnt %b busy %b done %b expected 0000 0 0000", gnt, busy, done); end
  endtask

  task automatic test_fairness();
    int idle;
    bit ok;
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      wait_grant(idle, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fair_grant_timeout op %0d: no grant within 20 cycles, expected %b", k, exp); end
      checks++; if (gnt !== exp) begin failures++; $display("FAIL fair_order op %0d: got %b expected %b", k, gnt, exp); end
      if (k > 0) begin
        checks++; if (idle < 1) begin failures++; $display("FAIL fair_idle_gap op %0d: got %0d idle cycles expected >=1", k, idle); end
      end
      adv_to(27);
      core_done = 1'b1;
      adv();
      checks++; if (done !== exp || err !== 1'b0) begin failures++; $display("FAIL fair_done op %0d: got %b err %b expected %b err 0", k, done, err, exp); end
      core_done = 1'b0;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int idle;
    bit ok;
    req = 4'b0010;
    wait_grant(idle, ok);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wd_gnt: got %b expected 0010", gnt); end
    adv_to(65);
    checks++; if (done_seen !== 0 || busy !== 1'b1) begin failures++; $display("FAIL wd_early: done pulses %0d busy %b expected 0 and 1", done_seen, busy); end
    adv();
    checks++; if (done !== 4'b0010 || err !== 1'b1) begin failures++; $display("FAIL wd_abort: got %b err %b expected 0010 err 1", done, err); end
    req = 4'b0111;
    adv();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wd_idle: busy %b err %b expected 0 0", busy, err); end
    wait_grant(idle, ok);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wd_ptr_advance: got %b expected 0100", gnt); end
    adv_to(27);
    core_done = 1'b1;
    adv();
    checks++; if (done !== 4'b0100 || err !== 1'b0) begin failures++; $display("FAIL wd_next_done: got %b err %b expected 0100 err 0", done, err); end
    core_done = 1'b0; req = '0;
    adv();
  endtask

  task automatic test_not_ready();
    core_ready = 1'b0; req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || start !== 1'b0) begin failures++; $display("FAIL nr_hold cycle %0d: gnt %b start %b expected 0000 0", i, gnt, start); end
    end
    core_ready = 1'b1;
    @(negedge clk);
    cyc = 1; done_seen = 0; start_seen = 0;
    checks++; if (gnt !== 4'b0001 || start !== 1'b1) begin failures++; $display("FAIL nr_grant: gnt %b start %b expected 0001 1", gnt, start); end
    adv_to(27);
    core_done = 1'b1;
    adv();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL nr_done: got %b expected 0001", done); end
    core_done = 1'b0; req = '0;
    adv();
  endtask

  task automatic test_reset_mid_wait();
    req = 4'b1111;
    @(negedge clk);
    cyc = 1; done_seen = 0; start_seen = 0;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rst_mid_pre_gnt: got %b expected 0010", gnt); end
    adv_to(10);
    rst = 1'b1;
    adv();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs: gnt %b done %b err %b expected 0000 0000 0", gnt, done, err); end
    checks++; if (busy !== 1'b0 || start !== 1'b0 || gnt_idx !== 2'd0) begin failures++; $display("FAIL rst_mid_state: busy %b start %b idx %0d expected 0 0 0", busy, start, gnt_idx); end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_seen); end
    rst = 1'b0;
    @(negedge clk);
    cyc = 1; done_seen = 0; start_seen = 0;
    checks++; if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin failures++; $display("FAIL rst_mid_first_win: gnt %b idx %0d expected 0001 idx 0", gnt, gnt_idx); end
    adv_to(27);
    core_done = 1'b1;
    adv();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL rst_mid_done: got %b expected 0001", done); end
    core_done = 1'b0; req = '0;
    adv();
  endtask

  task automatic test_drop_late_done();
    req = 4'b1000;
    @(negedge clk);
    cyc = 1; done_seen = 0; start_seen = 0;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL drop_gnt: got %b expected 1000", gnt); end
    adv();
    req = 4'b0000;
    adv_to(65);
    checks++; if (done !== 4'b0000 || busy !== 1'b1 || gnt !== 4'b1000) begin failures++; $display("FAIL drop_hold: done %b busy %b gnt %b expected 0000 1 1000", done, busy, gnt); end
    core_done = 1'b1;
    adv();
    checks++; if (done !== 4'b1000 || err !== 1'b0) begin failures++; $display("FAIL drop_done_wins: got %b err %b expected 1000 err 0", done, err); end
    checks++; if (done_seen !== 1) begin failures++; $display("FAIL drop_single_pulse: got %0d expected 1", done_seen); end
    core_done = 1'b0;
    adv();
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL drop_idle: busy %b gnt %b expected 0 0000", busy, gnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_watchdog();
    test_not_ready();
    test_reset_mid_wait();
    test_drop_late_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
